// File: rtl/rot_pkg.sv
// ---------------------------------------------------------------------------
// rot_pkg : shared encodings for the root-of-trust CPU reset controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rot_pkg;

  localparam logic [15:0] c_reset_handler_def = 16'hfffe;

  localparam int          c_state_w   = 2;
  localparam logic [1:0]  c_st_idle     = 2'd0;
  localparam logic [1:0]  c_st_stretch  = 2'd1;
  localparam logic [1:0]  c_st_wait_vec = 2'd2;

  localparam int c_cause_w    = 3;
  localparam int c_cause_atom = 0;
  localparam int c_cause_excl = 1;
  localparam int c_cause_tmo  = 2;

  localparam int c_count_w = 8;

  function automatic logic [c_count_w-1:0] sat_inc(input logic [c_count_w-1:0] v);
    return (v == {c_count_w{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rot_down_counter.sv
// ---------------------------------------------------------------------------
// rot_down_counter : loadable down counter with zero flag, stops at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rot_down_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/rot_reset_ctrl.sv
// ---------------------------------------------------------------------------
// rot_reset_ctrl : stretches CPU reset on security violations and re-resets
// if the CPU never fetches its reset vector. Optional macro ROT_VIOL_LOG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rot_reset_ctrl
  import rot_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER  = c_reset_handler_def,
  parameter int          STRETCH_CYCLES = 8,
  parameter int          WAIT_TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          pc,
  input  logic [1:0]           viol_in,
  input  logic                 cause_clr,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic [c_cause_w-1:0] viol_cause,
  output logic [c_count_w-1:0] viol_count,
  output logic [15:0]          viol_pc
);

  localparam logic [7:0] c_stretch_load = 8'(STRETCH_CYCLES - 1);
  localparam logic [7:0] c_wait_load    = 8'(WAIT_TIMEOUT - 1);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_next_state;
  logic                 r_cpu_reset;
  logic [c_cause_w-1:0] r_cause;
  logic [c_count_w-1:0] r_count;

  logic                 w_cnt_load;
  logic [7:0]           w_cnt_load_val;
  logic                 w_cnt_dec;
  logic                 w_cnt_zero;
  logic                 w_episode_start;
  logic                 w_timeout;
  logic [c_cause_w-1:0] w_viol_bits;

  // One counter suffices: stretch and vector-wait timing never overlap.
  rot_down_counter #(
    .WIDTH     (8),
    .RESET_VAL (c_stretch_load)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_comb begin
    w_viol_bits               = '0;
    w_viol_bits[c_cause_atom] = viol_in[0];
    w_viol_bits[c_cause_excl] = viol_in[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_stretch;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_cpu_reset <= (w_next_state == c_st_stretch);
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_cnt_load      = 1'b0;
    w_cnt_load_val  = c_stretch_load;
    w_cnt_dec       = 1'b0;
    w_episode_start = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (|viol_in) begin
          w_next_state    = c_st_stretch;
          w_cnt_load      = 1'b1;
          w_episode_start = 1'b1;
        end
      end
      c_st_stretch: begin
        if (w_cnt_zero) begin
          w_next_state   = c_st_wait_vec;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = c_wait_load;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      c_st_wait_vec: begin
        // A vector fetch on the expiry cycle still counts as success.
        if (pc == RESET_HANDLER) begin
          w_next_state = c_st_idle;
        end else if (w_cnt_zero) begin
          w_next_state = c_st_stretch;
          w_cnt_load   = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_next_state = c_st_stretch;
        w_cnt_load   = 1'b1;
      end
    endcase
  end

  always_comb begin
    cpu_reset  = r_cpu_reset;
    busy       = (r_state != c_st_idle);
    viol_cause = r_cause;
    viol_count = r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_episode_start) begin
            r_cause <= cause_clr ? w_viol_bits : (r_cause | w_viol_bits);
          end else if (cause_clr) begin
            r_cause <= '0;
          end
        end
        c_st_stretch: r_cause <= r_cause | w_viol_bits;
        default: begin
          if (w_timeout) begin
            r_cause[c_cause_tmo] <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_episode_start || w_timeout) begin
      r_count <= sat_inc(r_count);
    end
  end

`ifdef ROT_VIOL_LOG_EN
  logic [15:0] r_viol_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_viol_pc <= '0;
    end else if (w_episode_start) begin
      r_viol_pc <= pc;
    end
  end

  assign viol_pc = r_viol_pc;
`else
  assign viol_pc = 16'h0000;
`endif

endmodule

`default_nettype wire
